pc_gen: RTL and testbench



---
 rtl/pc_pkg.sv | 24 ++
 rtl/pc_gen_ras.sv | 72 +++++++
 rtl/pc_gen.sv | 143 ++++++++++++++
 tb/tb_pc_gen.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the fetch-stage PC generator.
//   - pc_src_e   : next-PC source select (one value per mux leg)
//   - LOG2_IB    : byte-offset width for the default 4-byte instruction size
//   - log2_ib()  : same derivation for any power-of-2 instruction size
package pc_pkg;

  typedef enum logic [2:0] {
    SRC_RESET  = 3'd0,
    SRC_TRAP   = 3'd1,
    SRC_BRANCH = 3'd2,
    SRC_RET    = 3'd3,
    SRC_HOLD   = 3'd4,
    SRC_SEQ    = 3'd5
  } pc_src_e;

  localparam int unsigned INST_BYTES_DEF = 4;
  localparam int unsigned LOG2_IB        = $clog2(INST_BYTES_DEF);

  // Number of low address bits that are always zero in an aligned fetch.
  function automatic int unsigned log2_ib(input int unsigned ib);
    return $clog2(ib);
  endfunction

endpackage

// File: rtl/pc_gen_ras.sv
// ras_stack: small circular return-address stack.
// Ports:
//   clk          rising-edge clock
//   i_reset      synchronous active-high reset (empties the stack)
//   i_push       write i_push_data as the new top
//   i_pop        discard the top entry
//   i_flush      empty the stack (trap)
//   i_push_data  return address to push
//   o_top        current top entry (valid only when !o_empty)
//   o_empty      no entries held
//   o_full       DEPTH entries held
// Priority inside the stack: flush, then push, then pop.
module ras_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_push_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_ptr;    // next slot to write; top lives at r_ptr-1
  logic [CW-1:0]    r_count;  // saturates at DEPTH
  logic [PW-1:0]    w_top_idx;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_top_idx = r_ptr - PW'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_do_push = i_push & ~i_flush;
  assign w_do_pop  = i_pop & ~i_flush & ~i_push & ~o_empty;

  // Storage carries no reset: an empty count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_ptr] <= i_push_data;
    end
  end

  // Pushing into a full stack overwrites the oldest slot because the pointer
  // simply wraps; the count stays pinned at DEPTH.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (w_do_push) begin
      r_ptr <= r_ptr + PW'(1);
      if (!o_full) begin
        r_count <= r_count + CW'(1);
      end
    end else if (w_do_pop) begin
      r_ptr   <= r_ptr - PW'(1);
      r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage-1 program-counter generator with a return-address stack.
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   stall         hold the PC (fetch back-pressure)
//   pcSrc         redirect to branchAddr this cycle
//   branchAddr    branch/jump target (low bits dropped to instruction alignment)
//   call          with pcSrc: jump-and-link, pushes addrOut+INST_BYTES
//   ret           redirect to the RAS top
//   trap          redirect to TRAP_VEC and flush the RAS
//   addrOut       registered fetch address
//   addrValid     addrOut is a legal fetch address
//   misalign      one-cycle pulse: accepted branchAddr had nonzero low bits
//   rasUnderflow  one-cycle pulse: ret found the RAS empty
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(32'h100),
  parameter int unsigned     INST_BYTES = 4,
  parameter int unsigned     RAS_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            pcSrc,
  input  logic [XLEN-1:0] branchAddr,
  input  logic            call,
  input  logic            ret,
  input  logic            trap,
  output logic [XLEN-1:0] addrOut,
  output logic            addrValid,
  output logic            misalign,
  output logic            rasUnderflow
);

  localparam int unsigned IB_SHIFT = log2_ib(INST_BYTES);

  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic            r_misalign;
  logic            r_underflow;

  pc_src_e         w_src;
  logic [XLEN-1:0] w_seq;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_ras_top;
  logic            w_ras_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_flush;
  logic            w_misalign;
  logic            w_underflow;

  // Modulo-2^XLEN increment: the top of the address space wraps to 0.
  assign w_seq    = r_pc + XLEN'(INST_BYTES);
  assign w_target = {branchAddr[XLEN-1:IB_SHIFT], {IB_SHIFT{1'b0}}};

  always_comb begin
    w_src       = SRC_SEQ;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_flush     = 1'b0;
    w_misalign  = 1'b0;
    w_underflow = 1'b0;
    if (reset) begin
      w_src = SRC_RESET;
    end else if (!r_valid) begin
      // First edge out of reset: RESET_VEC becomes the first valid fetch
      // rather than being skipped over.
      w_src = SRC_HOLD;
    end else if (trap) begin
      w_src   = SRC_TRAP;
      w_flush = 1'b1;
    end else if (pcSrc) begin
      // Redirect overrides stall; call here also wins over a concurrent ret.
      w_src      = SRC_BRANCH;
      w_push     = call;
      w_misalign = |branchAddr[IB_SHIFT-1:0];
    end else if (ret && !stall) begin
      if (!w_ras_empty) begin
        w_src = SRC_RET;
        w_pop = 1'b1;
      end else begin
        w_src       = SRC_SEQ;
        w_underflow = 1'b1;
      end
    end else if (stall) begin
      w_src = SRC_HOLD;
    end
  end

  always_comb begin
    w_next_pc = w_seq;
    case (w_src)
      SRC_RESET:  w_next_pc = RESET_VEC;
      SRC_TRAP:   w_next_pc = TRAP_VEC;
      SRC_BRANCH: w_next_pc = w_target;
      SRC_RET:    w_next_pc = w_ras_top;
      SRC_HOLD:   w_next_pc = r_pc;
      default:    w_next_pc = w_seq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_VEC;
      r_valid     <= 1'b0;
      r_misalign  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_pc        <= w_next_pc;
      r_valid     <= 1'b1;
      r_misalign  <= w_misalign;
      r_underflow <= w_underflow;
    end
  end

  // Fullness is handled inside the stack by circular overwrite, so the
  // generator never needs to look at it.
  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (XLEN)
  ) u_ras (
    .clk         (clk),
    .i_reset     (reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .i_push_data (w_seq),
    .o_top       (w_ras_top),
    .o_empty     (w_ras_empty),
    .o_full      ()
  );

  assign addrOut      = r_pc;
  assign addrValid    = r_valid;
  assign misalign     = r_misalign;
  assign rasUnderflow = r_underflow;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        pcSrc;
  logic [31:0] branchAddr;
  logic        call;
  logic        ret;
  logic        trap;
  logic [31:0] addrOut;
  logic        addrValid;
  logic        misalign;
  logic        rasUnderflow;

  int n_checks = 0;
  int n_fail   = 0;
  int n_step   = 0;

  pc_gen dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .pcSrc        (pcSrc),
    .branchAddr   (branchAddr),
    .call         (call),
    .ret          (ret),
    .trap         (trap),
    .addrOut      (addrOut),
    .addrValid    (addrValid),
    .misalign     (misalign),
    .rasUnderflow (rasUnderflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        ps;
    logic        cl;
    logic        rt;
    logic        tp;
    logic [31:0] ba;
    logic [31:0] pc;
    logic        v;
    logic        m;
    logic        u;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic stl, input logic ps,
                              input logic cl, input logic rt, input logic tp,
                              input logic [31:0] ba, input logic [31:0] pc,
                              input logic v, input logic m, input logic u);
    vec_t r;
    r.rst = rst; r.stl = stl; r.ps = ps; r.cl = cl; r.rt = rt; r.tp = tp;
    r.ba = ba; r.pc = pc; r.v = v; r.m = m; r.u = u;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL step %0d %s: got 0x%08h expected 0x%08h", n_step, name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare all outputs.
  task automatic step(input vec_t t);
    @(negedge clk);
    reset = t.rst; stall = t.stl; pcSrc = t.ps; call = t.cl;
    ret = t.rt; trap = t.tp; branchAddr = t.ba;
    @(posedge clk);
    #1;
    $display("step %0d: rst=%0b stl=%0b ps=%0b cl=%0b rt=%0b tp=%0b ba=0x%08h -> pc=0x%08h v=%0b m=%0b u=%0b",
             n_step, t.rst, t.stl, t.ps, t.cl, t.rt, t.tp, t.ba,
             addrOut, addrValid, misalign, rasUnderflow);
    chk("addrOut", addrOut, t.pc);
    chk("addrValid", 32'(addrValid), 32'(t.v));
    chk("misalign", 32'(misalign), 32'(t.m));
    chk("rasUnderflow", 32'(rasUnderflow), 32'(t.u));
    n_step++;
  endtask

  vec_t tbl[$];

  initial begin
    reset = 1'b1; stall = 1'b0; pcSrc = 1'b0; call = 1'b0;
    ret = 1'b0; trap = 1'b0; branchAddr = '0;

    //                 rst stl ps cl rt tp  branchAddr     addrOut        v  m  u
    // Reset sequence and sequential run-up to 16.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         32'h4,         1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         32'h8,         1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         32'hC,         1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         32'h10,        1, 0, 0));
    // Branch to 44, stall three cycles, resume.
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'd44,        32'd44,        1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,         32'd44,        1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,         32'd44,        1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,         32'd44,        1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         32'd48,        1, 0, 0));
    // Misaligned target 23 -> 20 with a single-cycle pulse.
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'd23,        32'd20,        1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         32'd24,        1, 0, 0));
    // Call from 0x40, return, then an underflowing return.
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h40,        32'h40,        1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 32'h200,       32'h200,       1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         32'h204,       1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         32'h208,       1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,         32'h44,        1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,         32'h48,        1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         32'h4C,        1, 0, 0));
    // ret under stall: held, no underflow.
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0,         32'h4C,        1, 0, 0));
    // call+ret together: call wins (push 0x50), then stalled ret keeps it.
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 32'h300,       32'h300,       1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0,         32'h300,       1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0,         32'h50,        1, 0, 0));
    // Wrap-around at the top of the address space.
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         32'h0,         1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         32'h4,         1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i]);
    end

    // RAS overflow: five nested calls into a 4-deep stack.
    step(mk(0, 0, 1, 0, 0, 0, 32'h10, 32'h10, 1, 0, 0));
    step(mk(0, 0, 1, 1, 0, 0, 32'h20, 32'h20, 1, 0, 0));
    step(mk(0, 0, 1, 1, 0, 0, 32'h30, 32'h30, 1, 0, 0));
    step(mk(0, 0, 1, 1, 0, 0, 32'h40, 32'h40, 1, 0, 0));
    step(mk(0, 0, 1, 1, 0, 0, 32'h50, 32'h50, 1, 0, 0));
    step(mk(0, 0, 1, 1, 0, 0, 32'h80, 32'h80, 1, 0, 0));
    step(mk(0, 0, 0, 0, 1, 0, 32'h0,  32'h54, 1, 0, 0));
    step(mk(0, 0, 0, 0, 1, 0, 32'h0,  32'h44, 1, 0, 0));
    step(mk(0, 0, 0, 0, 1, 0, 32'h0,  32'h34, 1, 0, 0));
    step(mk(0, 0, 0, 0, 1, 0, 32'h0,  32'h24, 1, 0, 0));
    step(mk(0, 0, 0, 0, 1, 0, 32'h0,  32'h28, 1, 0, 1));

    // Trap beats pcSrc, call and stall, and flushes a non-empty RAS.
    step(mk(0, 0, 1, 1, 0, 0, 32'h500, 32'h500, 1, 0, 0));
    step(mk(0, 1, 1, 1, 0, 1, 32'h600, 32'h100, 1, 0, 0));
    step(mk(0, 0, 0, 0, 1, 0, 32'h0,   32'h104, 1, 0, 1));

    // Reset mid-operation discards RAS contents.
    step(mk(0, 0, 1, 1, 0, 0, 32'h700, 32'h700, 1, 0, 0));
    step(mk(1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   1, 0, 0));
    step(mk(0, 0, 0, 0, 1, 0, 32'h0,   32'h4,   1, 0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
